// File: rtl/exe_mem_register_pkg.sv
// Shared definitions for the EXE/MEM pipeline register: default widths,
// the link register index and the memory-wait FSM encoding.
package exe_mem_register_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int REG_AW_DEFAULT = 5;
    localparam int REG_RA         = 31;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } wait_state_e;

endpackage

// File: rtl/exe_mem_wait_fsm.sv
// Tracks an outstanding data-memory access held in the EXE/MEM register and
// raises a same-cycle freeze request while the memory has not completed it.
module exe_mem_wait_fsm
    import exe_mem_register_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_mem_read,
    input  logic in_mem_write,
    input  logic mem_ready,
    output logic out_mem_busy,
    output logic out_mem_stall
);

    wait_state_e r_state;
    logic        w_mem_busy;

    // Bubbles never stall, whatever mem_ready does.
    assign w_mem_busy    = in_valid & (in_mem_read | in_mem_write) & ~mem_ready;
    assign out_mem_busy  = w_mem_busy;
    assign out_mem_stall = w_mem_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN:      if (w_mem_busy) r_state <= MEM_WAIT;
                MEM_WAIT: if (mem_ready)  r_state <= RUN;
                default:  r_state <= RUN;
            endcase
        end
    end

endmodule

// File: rtl/exe_mem_register.sv
// EXE/MEM pipeline register: selects ALU result or link value, holds while
// memory is busy or the hazard unit stalls, and loads bubbles on flush.
module exe_mem_register
    import exe_mem_register_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [DATA_W-1:0] in_pc_plus8,
    input  logic [REG_AW-1:0] in_dest_addr,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_mem_to_reg,
    input  logic              in_link,
    input  logic              in_stall,
    input  logic              in_flush,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_AW-1:0] out_dest_addr,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_mem_to_reg,
    output logic              out_valid,
    output logic              out_mem_stall
);

    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_store_data;
    logic [REG_AW-1:0] r_dest_addr;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_to_reg;
    logic              r_valid;

    logic              w_mem_busy;
    logic [DATA_W-1:0] w_result;
    logic              w_reg_write;

    assign w_result    = in_link ? in_pc_plus8 : in_alu_result;
    // Writes to $zero are dropped here so later stages never forward them.
    assign w_reg_write = in_reg_write & (in_dest_addr != '0);

    exe_mem_wait_fsm u_wait_fsm (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (r_valid),
        .in_mem_read  (r_mem_read),
        .in_mem_write (r_mem_write),
        .mem_ready    (mem_ready),
        .out_mem_busy (w_mem_busy),
        .out_mem_stall(out_mem_stall)
    );

    // NOTE: every branch either assigns all registers or none; the empty
    // hold branches rely on flop feedback, which is safe in always_ff.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result     <= '0;
            r_store_data <= '0;
            r_dest_addr  <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_valid      <= 1'b0;
        end else if (w_mem_busy) begin
            // In-flight access wins over flush; upstream re-presents it.
        end else if (in_flush) begin
            r_result     <= '0;
            r_store_data <= '0;
            r_dest_addr  <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_valid      <= 1'b0;
        end else if (!in_stall) begin
            r_result     <= w_result;
            r_store_data <= in_store_data;
            r_dest_addr  <= in_dest_addr;
            r_reg_write  <= w_reg_write;
            r_mem_read   <= in_mem_read;
            r_mem_write  <= in_mem_write;
            r_mem_to_reg <= in_mem_to_reg;
            r_valid      <= 1'b1;
        end
    end

    assign out_result     = r_result;
    assign out_store_data = r_store_data;
    assign out_dest_addr  = r_dest_addr;
    assign out_reg_write  = r_reg_write;
    assign out_mem_read   = r_mem_read;
    assign out_mem_write  = r_mem_write;
    assign out_mem_to_reg = r_mem_to_reg;
    assign out_valid      = r_valid;

endmodule

// File: tb/tb_exe_mem_register.sv
// Self-checking bench for exe_mem_register: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_exe_mem_register;
    import exe_mem_register_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic [DW-1:0] result;
        logic [DW-1:0] store;
        logic [AW-1:0] dest;
        logic          rw;
        logic          mr;
        logic          mw;
        logic          m2r;
        logic          valid;
    } regs_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] in_alu_result = '0;
    logic [DW-1:0] in_store_data = '0;
    logic [DW-1:0] in_pc_plus8 = '0;
    logic [AW-1:0] in_dest_addr = '0;
    logic          in_reg_write = 1'b0;
    logic          in_mem_read = 1'b0;
    logic          in_mem_write = 1'b0;
    logic          in_mem_to_reg = 1'b0;
    logic          in_link = 1'b0;
    logic          in_stall = 1'b0;
    logic          in_flush = 1'b0;
    logic          mem_ready = 1'b1;
    logic [DW-1:0] out_result;
    logic [DW-1:0] out_store_data;
    logic [AW-1:0] out_dest_addr;
    logic          out_reg_write;
    logic          out_mem_read;
    logic          out_mem_write;
    logic          out_mem_to_reg;
    logic          out_valid;
    logic          out_mem_stall;

    int    n_checks = 0;
    int    n_fail   = 0;
    regs_t m_regs   = '0;
    logic  m_wait   = 1'b0;

    always #5 clk = ~clk;

    exe_mem_register #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_alu_result (in_alu_result),
        .in_store_data (in_store_data),
        .in_pc_plus8   (in_pc_plus8),
        .in_dest_addr  (in_dest_addr),
        .in_reg_write  (in_reg_write),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .in_mem_to_reg (in_mem_to_reg),
        .in_link       (in_link),
        .in_stall      (in_stall),
        .in_flush      (in_flush),
        .mem_ready     (mem_ready),
        .out_result    (out_result),
        .out_store_data(out_store_data),
        .out_dest_addr (out_dest_addr),
        .out_reg_write (out_reg_write),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
        .out_mem_to_reg(out_mem_to_reg),
        .out_valid     (out_valid),
        .out_mem_stall (out_mem_stall)
    );

    function automatic regs_t observed();
        return '{out_result, out_store_data, out_dest_addr, out_reg_write,
                 out_mem_read, out_mem_write, out_mem_to_reg, out_valid};
    endfunction

    function automatic logic dut_state();
        return logic'(dut.u_wait_fsm.r_state);
    endfunction

    // Memory is busy when a real load/store sits in the register and memory is not done.
    function automatic logic model_busy();
        return m_regs.valid && (m_regs.mr || m_regs.mw) && !mem_ready;
    endfunction

    // Advance the model with the inputs seen at this edge.
    task automatic model_update();
        logic busy;
        busy = model_busy();
        if (reset) begin
            m_regs = '0;
            m_wait = 1'b0;
        end else begin
            m_wait = busy;
            if (busy) begin
                m_regs = m_regs;
            end else if (in_flush) begin
                m_regs = '0;
            end else if (!in_stall) begin
                m_regs.result = in_link ? in_pc_plus8 : in_alu_result;
                m_regs.store  = in_store_data;
                m_regs.dest   = in_dest_addr;
                m_regs.rw     = in_reg_write && (in_dest_addr != 0);
                m_regs.mr     = in_mem_read;
                m_regs.mw     = in_mem_write;
                m_regs.m2r    = in_mem_to_reg;
                m_regs.valid  = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        @(negedge clk);
        reset = 1'b0; in_link = 1'b0; in_stall = 1'b0; in_flush = 1'b0;
        in_reg_write = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        in_mem_to_reg = 1'b0; mem_ready = 1'b1; in_dest_addr = '0;
        in_alu_result = $urandom; in_store_data = $urandom; in_pc_plus8 = $urandom;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; in_alu_result = $urandom; in_reg_write = 1'b1;
        in_mem_read = 1'b1; in_dest_addr = 5'd3; mem_ready = 1'b0;
        cycle();
        n_checks++;
        if (observed() !== regs_t'('0)) begin
            n_fail++; $display("FAIL reset_regs: got %h expected 0", observed());
        end
        n_checks++;
        if (out_mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b expected 0", out_mem_stall);
        end
        n_checks++;
        if (dut_state() !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: got %b expected RUN", dut_state());
        end
    endtask

    task automatic test_load();
        clear_inputs();
        in_alu_result = 32'h0000_1234; in_dest_addr = 5'd8; in_reg_write = 1'b1;
        cycle();
        n_checks++;
        if ({out_result, out_dest_addr, out_valid, out_reg_write} !== {32'h0000_1234, 5'd8, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL load: got res=%h dest=%0d v=%b rw=%b expected 1234/8/1/1",
                               out_result, out_dest_addr, out_valid, out_reg_write);
        end
        n_checks++;
        if (out_store_data !== in_store_data) begin
            n_fail++; $display("FAIL load_store_data: got %h expected %h", out_store_data, in_store_data);
        end
    endtask

    task automatic test_link();
        clear_inputs();
        in_link = 1'b1; in_pc_plus8 = 32'h0040_0010; in_dest_addr = 5'(REG_RA); in_reg_write = 1'b1;
        in_alu_result = 32'hdead_beef;
        cycle();
        n_checks++;
        if ({out_result, out_dest_addr, out_reg_write} !== {32'h0040_0010, 5'd31, 1'b1}) begin
            n_fail++; $display("FAIL link: got res=%h dest=%0d rw=%b expected 00400010/31/1",
                               out_result, out_dest_addr, out_reg_write);
        end
    endtask

    task automatic test_dest_zero();
        clear_inputs();
        in_dest_addr = 5'd0; in_reg_write = 1'b1;
        cycle();
        n_checks++;
        if ({out_reg_write, out_valid} !== 2'b01) begin
            n_fail++; $display("FAIL dest_zero: got rw=%b v=%b expected rw=0 v=1", out_reg_write, out_valid);
        end
    endtask

    task automatic test_flush_stall();
        logic [DW-1:0] held;
        clear_inputs();
        in_alu_result = 32'h0bad_f00d; in_dest_addr = 5'd12; in_reg_write = 1'b1; in_mem_to_reg = 1'b1;
        cycle();
        held = 32'h0bad_f00d;
        @(negedge clk);
        in_stall = 1'b1; in_alu_result = 32'h1111_2222; in_dest_addr = 5'd13;
        cycle();
        n_checks++;
        if ({out_result, out_dest_addr, out_valid} !== {held, 5'd12, 1'b1}) begin
            n_fail++; $display("FAIL stall_hold: got res=%h dest=%0d expected %h/12", out_result, out_dest_addr, held);
        end
        @(negedge clk);
        in_flush = 1'b1; mem_ready = 1'b0;
        cycle();
        n_checks++;
        if (observed() !== regs_t'('0)) begin
            n_fail++; $display("FAIL flush_bubble: got %h expected 0", observed());
        end
        n_checks++;
        if (out_mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL bubble_no_stall: got %b expected 0", out_mem_stall);
        end
    endtask

    task automatic test_mem_wait();
        clear_inputs();
        in_alu_result = 32'h1000_0040; in_dest_addr = 5'd9; in_reg_write = 1'b1;
        in_mem_read = 1'b1; in_mem_to_reg = 1'b1; mem_ready = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({out_mem_stall, out_result, out_valid, out_mem_read} !== {1'b1, 32'h1000_0040, 1'b1, 1'b1}) begin
                n_fail++; $display("FAIL wait_cycle%0d: got stall=%b res=%h expected stall=1 res=10000040",
                                   i, out_mem_stall, out_result);
            end
            if (i > 0) begin
                n_checks++;
                if (dut_state() !== 1'b1) begin
                    n_fail++; $display("FAIL wait_state%0d: got %b expected MEM_WAIT", i, dut_state());
                end
            end
            @(negedge clk);
            if (i < 2) begin
                in_alu_result = $urandom; in_flush = 1'b1; in_dest_addr = 5'd20;
                cycle();
            end else begin
                mem_ready = 1'b1;
            end
        end
        #1;
        n_checks++;
        if (out_mem_stall !== 1'b0) begin
            n_fail++; $display("FAIL wait_release: got stall=%b expected 0", out_mem_stall);
        end
        cycle();
        n_checks++;
        if ({dut_state(), out_valid} !== 2'b00) begin
            n_fail++; $display("FAIL wait_exit: got state=%b v=%b expected RUN, bubble", dut_state(), out_valid);
        end
    endtask

    task automatic test_reset_mid_wait();
        clear_inputs();
        in_mem_write = 1'b1; in_dest_addr = 5'd4; mem_ready = 1'b0;
        cycle();
        cycle();
        n_checks++;
        if ({dut_state(), out_mem_stall} !== 2'b11) begin
            n_fail++; $display("FAIL pre_reset_wait: got state=%b stall=%b expected 1/1", dut_state(), out_mem_stall);
        end
        @(negedge clk);
        reset = 1'b1;
        cycle();
        n_checks++;
        if ({out_valid, out_mem_stall, dut_state()} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid_wait: got v=%b stall=%b state=%b expected 0/0/RUN",
                               out_valid, out_mem_stall, dut_state());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            reset         = ($urandom_range(0, 49) == 0);
            in_alu_result = $urandom;
            in_store_data = $urandom;
            in_pc_plus8   = $urandom;
            in_dest_addr  = AW'($urandom_range(0, 7) == 0 ? 0 : $urandom);
            in_reg_write  = 1'($urandom);
            in_mem_read   = ($urandom_range(0, 2) == 0);
            in_mem_write  = ($urandom_range(0, 3) == 0);
            in_mem_to_reg = 1'($urandom);
            in_link       = ($urandom_range(0, 4) == 0);
            in_stall      = ($urandom_range(0, 6) == 0);
            in_flush      = ($urandom_range(0, 9) == 0);
            mem_ready     = ($urandom_range(0, 9) < 6);
            #1;
            n_checks++;
            if (out_mem_stall !== model_busy()) begin
                n_fail++; $display("FAIL rand_stall@%0d: got %b expected %b", i, out_mem_stall, model_busy());
            end
            cycle();
            n_checks++;
            if (observed() !== m_regs) begin
                n_fail++; $display("FAIL rand_regs@%0d: got %h expected %h", i, observed(), m_regs);
            end
            n_checks++;
            if (dut_state() !== m_wait) begin
                n_fail++; $display("FAIL rand_state@%0d: got %b expected %b", i, dut_state(), m_wait);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_link();
        test_dest_zero();
        test_flush_stall();
        test_mem_wait();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
